// File: rtl/uart_rx.sv
// Purpose: 8N1 UART receiver with a 2-flop input synchronizer, mid-bit sampling and framing-error detection.
// Latency: rx_valid/frame_err pulse one cycle after the mid-stop-bit sample (edge on rx_s + CPB/2 + 9*CPB + 1).
// Backpressure: none; rx_data is overwritten by each good frame and rx_valid is a single-cycle strobe.
module uart_rx #(
  parameter int CPB = 50000000 / 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam logic [15:0] HALF_LAST = 16'(CPB / 2 - 1);
  localparam logic [15:0] BIT_LAST  = 16'(CPB - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic       rx_m;
  logic       rx_s;
  logic       rx_d;
  logic [1:0] sync_fill;
  logic       armed;
  state_t     state;
  logic [15:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;

  // Synchronize the pin and arm edge detection only once a genuine high has reached rx_s,
  // so the reset value of the synchronizer never masquerades as a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      rx_d      <= 1'b1;
      sync_fill <= 2'b00;
      armed     <= 1'b0;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      rx_d      <= rx_s;
      sync_fill <= {sync_fill[0], 1'b1};
      if (sync_fill[1] && rx_s) begin
        armed <= 1'b1;
      end
    end
  end

  // Frame FSM: start-bit qualification at half a bit, data bits every CPB, stop check mid-bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 16'd0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= 16'd0;
          bit_idx <= 3'd0;
          if (armed && rx_d && !rx_s) begin
            state <= START;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= 16'd0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= 16'd0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= 16'd0;
            state <= IDLE;
            if (rx_s) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 16'd0;
        end
      endcase
    end
  end

  assign rx_busy = (state != IDLE);

endmodule
